// File: rtl/regfile_write_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU writeback and load return.
// Optional XZR_DROP_EN: accepted writes to register 31 handshake normally but never assert reg_write.
module regfile_write_port_arbiter #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_addr,
   input  logic [DATA_WIDTH-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_ready,
   output logic                  reg_write,
   output logic [ADDR_WIDTH-1:0] write_reg_address,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  last_grant,
   output logic [CNT_WIDTH-1:0]  contention_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
`ifdef XZR_DROP_EN
   localparam logic [ADDR_WIDTH-1:0] XZR_ADDR = ADDR_WIDTH'(31);
`endif

   logic                  rr_ptr;
   logic                  alu_grant;
   logic                  mem_grant;
   logic                  both_valid;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   // Grant decode: rr_ptr only matters when both requesters are valid.
   always_comb begin
      both_valid = alu_valid && mem_valid;
      alu_grant  = reset_n && alu_valid && (!mem_valid || !rr_ptr);
      mem_grant  = reset_n && mem_valid && (!alu_valid || rr_ptr);
      sel_addr   = mem_grant ? mem_addr : alu_addr;
      sel_data   = mem_grant ? mem_data : alu_data;
`ifdef XZR_DROP_EN
      wr_en      = (alu_grant || mem_grant) && (sel_addr != XZR_ADDR);
`else
      wr_en      = alu_grant || mem_grant;
`endif
   end

   assign alu_ready = alu_grant;
   assign mem_ready = mem_grant;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         reg_write         <= 1'b0;
         write_reg_address <= '0;
         data              <= '0;
         last_grant        <= 1'b0;
         rr_ptr            <= 1'b0;
         contention_count  <= '0;
      end else begin
         reg_write <= wr_en;
         if (alu_grant || mem_grant) begin
            write_reg_address <= sel_addr;
            data              <= sel_data;
            last_grant        <= mem_grant;
            rr_ptr            <= alu_grant;
         end
         if (both_valid && (contention_count != CNT_MAX))
            contention_count <= contention_count + CNT_WIDTH'(1);
      end
   end

endmodule
